alu_control_sequencer: RTL and testbench
========================================

# alu_control_sequencer

Multi-cycle control sequencer that accepts 32-bit RV32I R-type instruction words over a valid/ready handshake. It decodes each word into the register-select, ALU-opcode and write-enable signals consumed by the register-file/ALU datapath, and sequences them so each instruction performs exactly one register write-back. It sits between the instruction source and the datapath, driving its control inputs and observing its zero flag.

## Interface
- `XLEN`, 32: instruction word width; only 32 is supported.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `instr_valid` input 1: `instr` holds a valid word.
- `instr` input XLEN: instruction word.
- `instr_ready` output 1: sequencer can accept a word.
- `zero_flag` input 1: ALU zero flag from the datapath.
- `read_reg1` output 5: rs1, `instr[19:15]`.
- `read_reg2` output 5: rs2, `instr[24:20]`.
- `write_reg` output 5: rd, `instr[11:7]`.
- `alu_control` output 4: ALU operation select.
- `write_on_register` output 1: register-file write enable, one-cycle pulse.
- `zero_latched` output 1: `zero_flag` captured for the last executed instruction.
- `illegal_instr` output 1: one-cycle pulse when a rejected word is dropped.
- `retired_count` output 32: count of instructions that completed write-back (see Configuration).

## Operation
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK. Reset state is IDLE.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready` at a rising edge, latch `instr` and go to DECODE. Otherwise stay in IDLE.
- DECODE:
  - Drive `read_reg1`, `read_reg2`, `write_reg` and `alu_control` from the latched word.
  - Legal means `opcode` (`[6:0]`)=0110011 and the funct7/funct3 pair is listed below. A legal word goes to EXECUTE.
  - An illegal word pulses `illegal_instr` for one cycle, returns to IDLE and never writes.
- EXECUTE: hold the decode outputs. Capture `zero_flag` into `zero_latched` at the exiting edge, then go to WRITEBACK.
- WRITEBACK: hold the decode outputs. Assert `write_on_register` for this cycle only, except when rd=0, where it stays 0. Return to IDLE.
- `alu_control` encoding, as funct7/funct3 → code:
  - ADD 0000000/000 → 0010
  - SUB 0100000/000 → 0110
  - AND 0000000/111 → 0000
  - OR 0000000/110 → 0001
  - XOR 0000000/100 → 0011
  - SLL 0000000/001 → 0100
  - SRL 0000000/101 → 0101
  - SRA 0100000/101 → 1000
  - SLT 0000000/010 → 0111
  - SLTU 0000000/011 → 1001
- Any other funct7/funct3 combination is illegal.
- `read_reg1`, `read_reg2`, `write_reg` and `alu_control` hold their last decoded value while in IDLE.
- Write to x0 counts as retired; the write itself is suppressed.

## Timing
- Reset values: state IDLE, `instr_ready`=1, all other outputs 0, including `retired_count`.
- `instr_ready` is decoded from state. A handshake is ignored while `reset` is low.
- Accept at edge k:
  - decode outputs are valid after edge k+1;
  - `write_on_register` is high between edges k+2 and k+3, so the write lands on edge k+3;
  - `instr_ready` is back to 1 after edge k+3.
- Throughput is one instruction per 4 cycles. An illegal word costs 2 cycles.
- Back-to-back: a word held valid while `instr_ready`=0 stays pending and is accepted on the first IDLE cycle. No word is lost or duplicated.
- `instr` changing while not ready has no effect; only the latched copy is used.
- Reset asserted mid-operation: return immediately to IDLE and clear all outputs. An in-flight write is abandoned; no partial write or pulse follows deassertion.

## Configuration
- `CTRL_RETIRE_CNT_EN` defined:
  - `retired_count` increments by 1, with wrap-around from 0xFFFFFFFF to 0, on each WRITEBACK exit.
  - Illegal words do not count.
- Not defined: `retired_count` is constant 0 and no counter flops are synthesized. All other behaviour is identical.

## Test plan
- Reset low, release; offer `instr`=0x002081B3 (add x3,x1,x2) → `read_reg1`=1, `read_reg2`=2, `write_reg`=3, `alu_control`=0010; `write_on_register` high exactly one cycle, 3 edges after accept.
- Preload x1=5, x2=5; issue sub x4,x1,x2 (0x40208233) → `alu_control`=0110, `zero_latched`=1, x4=0.
- Issue add x0,x1,x2 (0x00208033) → no `write_on_register` pulse; `retired_count` increments with the macro defined, stays 0 without.
- Issue 0x00000013 (I-type addi) and then funct7=0000001/funct3=000 → `illegal_instr` pulses once each, no writes, `retired_count` unchanged.
- Hold `instr_valid` high with 3 distinct words queued → accepts exactly 4 cycles apart, 3 writes in order.
- Assert `reset` during EXECUTE → no write; all outputs 0, `instr_ready`=1 after release; next instruction executes normally.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: multi-cycle control sequencer for RV32I R-type words.
// Accepts a word over valid/ready, decodes register selects and the ALU opcode,
// then walks IDLE -> DECODE -> EXECUTE -> WRITEBACK issuing a single write pulse.
// Optional feature: define CTRL_RETIRE_CNT_EN to build the retired-instruction
// counter; otherwise retired_count is tied to zero.
module alu_control_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr,
  output logic            instr_ready,
  input  logic            zero_flag,
  output logic [4:0]      read_reg1,
  output logic [4:0]      read_reg2,
  output logic [4:0]      write_reg,
  output logic [3:0]      alu_control,
  output logic            write_on_register,
  output logic            zero_latched,
  output logic            illegal_instr,
  output logic [31:0]     retired_count
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_e;

  state_e          state_q;
  logic [XLEN-1:0] instr_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [3:0]      alu_q;
  logic            wr_q, zero_q, illegal_q;
  logic [3:0]      dec_alu_d;
  logic            dec_legal_d;

  // Decode the latched word: R-type opcode plus a known funct7/funct3 pair.
  always_comb begin
    dec_alu_d   = 4'b0000;
    dec_legal_d = 1'b0;
    if (instr_q[6:0] == 7'b0110011) begin
      dec_legal_d = 1'b1;
      case ({instr_q[31:25], instr_q[14:12]})
        {7'b0000000, 3'b000}: dec_alu_d = 4'b0010; // ADD
        {7'b0100000, 3'b000}: dec_alu_d = 4'b0110; // SUB
        {7'b0000000, 3'b111}: dec_alu_d = 4'b0000; // AND
        {7'b0000000, 3'b110}: dec_alu_d = 4'b0001; // OR
        {7'b0000000, 3'b100}: dec_alu_d = 4'b0011; // XOR
        {7'b0000000, 3'b001}: dec_alu_d = 4'b0100; // SLL
        {7'b0000000, 3'b101}: dec_alu_d = 4'b0101; // SRL
        {7'b0100000, 3'b101}: dec_alu_d = 4'b1000; // SRA
        {7'b0000000, 3'b010}: dec_alu_d = 4'b0111; // SLT
        {7'b0000000, 3'b011}: dec_alu_d = 4'b1001; // SLTU
        default:              dec_legal_d = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with registered control outputs; pulses default low each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      wr_q      <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          // Illegal words leave the previous decode outputs untouched.
          if (dec_legal_d) begin
            rs1_q   <= instr_q[19:15];
            rs2_q   <= instr_q[24:20];
            rd_q    <= instr_q[11:7];
            alu_q   <= dec_alu_d;
            state_q <= EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        EXECUTE: begin
          zero_q  <= zero_flag;
          wr_q    <= (rd_q != 5'd0);  // x0 retires but never writes
          state_q <= WRITEBACK;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // Count every WRITEBACK exit; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    retired_q <= '0;
    else if (state_q == WRITEBACK) retired_q <= retired_q + 32'd1;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

  assign instr_ready       = (state_q == IDLE);
  assign read_reg1         = rs1_q;
  assign read_reg2         = rs2_q;
  assign write_reg         = rd_q;
  assign alu_control       = alu_q;
  assign write_on_register = wr_q;
  assign zero_latched      = zero_q;
  assign illegal_instr     = illegal_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer with a small register-file/ALU model
// that consumes the control outputs and feeds back the zero flag.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        zero_flag;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [3:0]  alu_control;
  logic        write_on_register, zero_latched, illegal_instr;
  logic [31:0] retired_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_control_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .zero_flag(zero_flag),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .alu_control(alu_control), .write_on_register(write_on_register),
    .zero_latched(zero_latched), .illegal_instr(illegal_instr),
    .retired_count(retired_count)
  );

  // Datapath model: register file with x0 hardwired, ALU driven by alu_control.
  logic [31:0] rf [32];
  logic        preload = 1'b1;
  logic [31:0] opa, opb, res;

  always_comb begin
    opa = (read_reg1 == 5'd0) ? 32'd0 : rf[read_reg1];
    opb = (read_reg2 == 5'd0) ? 32'd0 : rf[read_reg2];
    case (alu_control)
      4'b0010: res = opa + opb;
      4'b0110: res = opa - opb;
      4'b0000: res = opa & opb;
      4'b0001: res = opa | opb;
      4'b0011: res = opa ^ opb;
      4'b0100: res = opa << opb[4:0];
      4'b0101: res = opa >> opb[4:0];
      4'b1000: res = $unsigned($signed(opa) >>> opb[4:0]);
      4'b0111: res = {31'd0, $signed(opa) < $signed(opb)};
      4'b1001: res = {31'd0, opa < opb};
      default: res = 32'd0;
    endcase
    zero_flag = (res == 32'd0);
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
      rf[1] <= 32'd5;
      rf[2] <= 32'd5;
    end else if (write_on_register && write_reg != 5'd0) begin
      rf[write_reg] <= res;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Offer one word, wait (bounded) for acceptance, run 3 more edges counting writes.
  task automatic issue(input string tag, input logic [31:0] w, output int pulses);
    int n;
    pulses = 0;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 10) begin tick(); n++; end
    check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    instr = $urandom;  // must not disturb the latched copy
    for (int c = 0; c < 3; c++) begin
      tick();
      if (write_on_register) pulses++;
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
`ifdef CTRL_RETIRE_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  logic [31:0] tbl_w [7];
  logic [3:0]  tbl_c [7];
  logic [31:0] b2b_w [3];
  int          acc_cyc [3];
  logic [4:0]  wr_seq [3];
  int          pulses, accepted, nwr, ill;

  initial begin
    tbl_w = '{32'h0020F033, 32'h0020C033, 32'h00209033, 32'h0020D033,
              32'h4020D033, 32'h0020A033, 32'h0020B033};
    tbl_c = '{4'b0000, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b0111, 4'b1001};
    b2b_w = '{32'h002082B3, 32'h40208333, 32'h0020E3B3};

    // Reset state
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_outs", {read_reg1, read_reg2, write_reg, alu_control,
                       write_on_register, zero_latched, illegal_instr}, 32'd0);
    check("rst_cnt", retired_count, 32'd0);
    tick(); tick();
    reset = 1'b1;
    preload = 1'b0;
    tick();

    // add x3,x1,x2 with cycle-exact timing
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    check("add_ready", {31'd0, instr_ready}, 32'd1);
    tick();  // edge k
    instr_valid = 1'b0;
    instr = 32'hFFFFFFFF;
    check("add_busy", {31'd0, instr_ready}, 32'd0);
    tick();  // k+1
    check("add_dec", {read_reg1, read_reg2, write_reg, alu_control}, {5'd1, 5'd2, 5'd3, 4'b0010});
    check("add_wr_k1", {31'd0, write_on_register}, 32'd0);
    tick();  // k+2
    check("add_wr_k2", {31'd0, write_on_register}, 32'd1);
    check("add_zero", {31'd0, zero_latched}, 32'd0);
    tick();  // k+3
    check("add_wr_k3", {31'd0, write_on_register}, 32'd0);
    check("add_ready_k3", {31'd0, instr_ready}, 32'd1);
    check("add_x3", rf[3], 32'd10);
    check("add_cnt", retired_count, cnt(1));

    // sub x4,x1,x2 -> zero result
    issue("sub", 32'h40208233, pulses);
    check("sub_alu", {28'd0, alu_control}, 32'h6);
    check("sub_zero", {31'd0, zero_latched}, 32'd1);
    check("sub_x4", rf[4], 32'd0);
    check("sub_pulses", pulses, 32'd1);

    // add x0 retires without writing
    issue("addx0", 32'h00208033, pulses);
    check("addx0_pulses", pulses, 32'd0);
    check("addx0_cnt", retired_count, cnt(3));

    // illegal: I-type addi, then funct7=0000001
    instr = 32'h00000013;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("ill1_pulse", {31'd0, illegal_instr}, 32'd1);
    check("ill1_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("ill1_clr", {31'd0, illegal_instr}, 32'd0);
    check("ill1_nowr", {31'd0, write_on_register}, 32'd0);
    instr = 32'h022082B3;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("ill2_pulse", {31'd0, illegal_instr}, 32'd1);
    tick(); tick();
    check("ill2_x5", rf[5], 32'h105);
    check("ill_cnt", retired_count, cnt(3));

    // Remaining opcodes, rd=x0 so no writes
    for (int i = 0; i < 7; i++) begin
      issue("tbl", tbl_w[i], pulses);
      check($sformatf("tbl_alu%0d", i), {28'd0, alu_control}, {28'd0, tbl_c[i]});
      check($sformatf("tbl_wr%0d", i), pulses, 32'd0);
    end
    check("tbl_cnt", retired_count, cnt(10));

    // Back-to-back: valid held high, next word presented after each accept
    accepted = 0;
    nwr = 0;
    instr = b2b_w[0];
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (instr_valid && instr_ready) begin
        acc_cyc[accepted] = cyc;
        accepted++;
      end
      tick();
      if (write_on_register && nwr < 3) begin wr_seq[nwr] = write_reg; nwr++; end
      if (accepted < 3) instr = b2b_w[accepted];
      else instr_valid = 1'b0;
    end
    check("b2b_acc", accepted, 32'd3);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd4);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd4);
    check("b2b_nwr", nwr, 32'd3);
    check("b2b_order", {17'd0, wr_seq[0], wr_seq[1], wr_seq[2]}, {17'd0, 5'd5, 5'd6, 5'd7});
    check("b2b_rf", {rf[5][7:0], rf[6][7:0], rf[7][7:0]}, 32'h000A0005);
    check("b2b_cnt", retired_count, cnt(13));

    // Reset during EXECUTE abandons the write
    instr = 32'h00208433;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();  // now in EXECUTE
    reset = 1'b0;
    #1;
    check("mid_ready", {31'd0, instr_ready}, 32'd1);
    check("mid_outs", {read_reg1, read_reg2, write_reg, alu_control,
                       write_on_register, zero_latched, illegal_instr}, 32'd0);
    check("mid_cnt", retired_count, 32'd0);
    tick();
    reset = 1'b1;
    ill = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (write_on_register || illegal_instr) ill++;
    end
    check("mid_nopulse", ill, 32'd0);
    check("mid_x8", rf[8], 32'h108);
    issue("post", 32'h002084B3, pulses);
    check("post_pulses", pulses, 32'd1);
    check("post_x9", rf[9], 32'd10);
    check("post_cnt", retired_count, cnt(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
